// File: rtl/simon_says_karuin33_if.sv
// Tiny Tapeout pin bundle for the Simon Says game: dedicated and bidirectional I/O
// grouped so the game core and its environment share one connection point.
interface simon_says_karuin33_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/simon_says_karuin33.sv
// Four-button Simon Says: plays an LFSR-generated colour sequence on the LEDs, one step
// longer each round, and checks the player's presses, reporting score, win and fail.
module simon_says_karuin33 #(
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned FAST_CYCLES = 16,
  parameter int unsigned MAX_LEVEL   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  simon_says_karuin33_if.slave tt_io
);

  localparam int unsigned MaxT   = (STEP_CYCLES > FAST_CYCLES) ? STEP_CYCLES : FAST_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxT + 1);
  localparam int unsigned LvlW   = $clog2(MAX_LEVEL + 1);
  localparam int unsigned IdxW   = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StShow,
    StInput,
    StRoundDone,
    StGap,
    StFail,
    StWin
  } state_e;

  // Input synchroniser: bits [4:0] are buttons/start, bit 5 carries the fast-mode select
  logic [5:0]            sync1_q, sync2_q;
  logic [4:0]            prev_q;
  logic [4:0]            rise;
  logic [3:0]            btn;
  logic                  start_edge;
  logic                  fast;

  logic [15:0]           lfsr_q;
  logic                  lfsr_fb;
  logic [1:0]            seq_q [MAX_LEVEL];
  logic                  fill_we;

  state_e                state_q, state_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [LvlW-1:0]       score_q, score_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [TimerW-1:0]     t_load;
  logic                  timer_zero;
  logic [IdxW-1:0]       show_idx_q, show_idx_d;
  logic [IdxW-1:0]       in_idx_q, in_idx_d;
  logic [IdxW-1:0]       fill_cnt_q, fill_cnt_d;
  logic                  show_on_q, show_on_d;
  logic                  blink_q, blink_d;

  logic [3:0]            leds;
  logic                  fail_flag, win_flag, await_flag, show_flag;
  logic                  unused_inputs;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  assign btn        = sync2_q[3:0];
  assign fast       = sync2_q[5];
  assign rise       = sync2_q[4:0] & ~prev_q;
  assign start_edge = rise[4];
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign t_load     = fast ? TimerW'(FAST_CYCLES - 1) : TimerW'(STEP_CYCLES - 1);
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      lfsr_q  <= 16'hACE1;
    end else begin
      sync1_q <= {tt_io.ui_in[7], tt_io.ui_in[4:0]};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[4:0];
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_LEVEL); i++) begin
        seq_q[i] <= '0;
      end
    end else if (fill_we) begin
      seq_q[fill_cnt_q] <= lfsr_q[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      level_q    <= '0;
      score_q    <= '0;
      timer_q    <= '0;
      show_idx_q <= '0;
      in_idx_q   <= '0;
      fill_cnt_q <= '0;
      show_on_q  <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      score_q    <= score_d;
      timer_q    <= timer_d;
      show_idx_q <= show_idx_d;
      in_idx_q   <= in_idx_d;
      fill_cnt_q <= fill_cnt_d;
      show_on_q  <= show_on_d;
      blink_q    <= blink_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    score_d    = score_q;
    timer_d    = timer_q;
    show_idx_d = show_idx_q;
    in_idx_d   = in_idx_q;
    fill_cnt_d = fill_cnt_q;
    show_on_d  = show_on_q;
    blink_d    = blink_q;
    fill_we    = 1'b0;

    case (state_q)
      StIdle, StWin: begin
        if (start_edge) begin
          state_d    = StFill;
          fill_cnt_d = '0;
          level_d    = '0;
          score_d    = '0;
        end
      end

      StFill: begin
        fill_we    = 1'b1;
        fill_cnt_d = fill_cnt_q + IdxW'(1);
        if (fill_cnt_q == IdxW'(MAX_LEVEL - 1)) begin
          state_d    = StShow;
          level_d    = LvlW'(1);
          show_idx_d = '0;
          show_on_d  = 1'b1;
          timer_d    = t_load;
        end
      end

      StShow: begin
        if (!timer_zero) begin
          timer_d = timer_q - TimerW'(1);
        end else if (show_on_q) begin
          show_on_d = 1'b0;
          timer_d   = t_load;
        end else if ((LvlW'(show_idx_q) + LvlW'(1)) == level_q) begin
          state_d  = StInput;
          in_idx_d = '0;
        end else begin
          show_idx_d = show_idx_q + IdxW'(1);
          show_on_d  = 1'b1;
          timer_d    = t_load;
        end
      end

      // Any rising button edge is judged against the whole vector, so a chord fails
      StInput: begin
        if (|rise[3:0]) begin
          if (btn == onehot(seq_q[in_idx_q])) begin
            if ((LvlW'(in_idx_q) + LvlW'(1)) == level_q) begin
              state_d = StRoundDone;
            end else begin
              in_idx_d = in_idx_q + IdxW'(1);
            end
          end else begin
            state_d = StFail;
            blink_d = 1'b1;
            timer_d = t_load;
          end
        end
      end

      StRoundDone: begin
        if (btn == 4'h0) begin
          score_d = level_q;
          if (level_q == LvlW'(MAX_LEVEL)) begin
            state_d = StWin;
          end else begin
            level_d = level_q + LvlW'(1);
            timer_d = t_load;
            state_d = StGap;
          end
        end
      end

      StGap: begin
        if (!timer_zero) begin
          timer_d = timer_q - TimerW'(1);
        end else begin
          state_d    = StShow;
          show_idx_d = '0;
          show_on_d  = 1'b1;
          timer_d    = t_load;
        end
      end

      StFail: begin
        if (start_edge) begin
          state_d    = StFill;
          fill_cnt_d = '0;
          level_d    = '0;
          score_d    = '0;
        end else if (!timer_zero) begin
          timer_d = timer_q - TimerW'(1);
        end else begin
          blink_d = ~blink_q;
          timer_d = t_load;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    leds       = 4'h0;
    fail_flag  = 1'b0;
    win_flag   = 1'b0;
    await_flag = 1'b0;
    show_flag  = 1'b0;
    case (state_q)
      StShow: begin
        show_flag = 1'b1;
        if (show_on_q) leds = onehot(seq_q[show_idx_q]);
      end
      StInput: begin
        await_flag = 1'b1;
        leds       = btn;
      end
      StFail: begin
        fail_flag = 1'b1;
        leds      = {4{blink_q}};
      end
      StWin: begin
        win_flag = 1'b1;
        leds     = 4'hF;
      end
      default: ;
    endcase
  end

  assign tt_io.uo_out  = {show_flag, await_flag, win_flag, fail_flag, leds};
  assign tt_io.uio_out = {{(8 - LvlW){1'b0}}, score_q};
  assign tt_io.uio_oe  = 8'hFF;

  assign unused_inputs = ^{tt_io.ena, tt_io.uio_in, tt_io.ui_in[6:5]};

endmodule

// File: tb/tb_simon_says_karuin33.sv
// Directed bench for the Simon Says game: learns the sequence from the LED display,
// replays it through a scoreboard, and checks fail, win, score and LFSR origin.
module tb_simon_says_karuin33;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  simon_says_karuin33_if bus ();

  simon_says_karuin33 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt_io (bus)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  logic [3:0] exp_q [$];
  logic [1:0] seq_obs [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] p);
    case (p)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Watch one SHOW phase of lvl steps; known steps come from the scoreboard, new ones are learnt
  task automatic observe_show(input int lvl);
    int         cnt;
    logic [3:0] pat;
    logic [3:0] e;
    cnt = 0;
    while (bus.uo_out[7] !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("show_start", 32'(bus.uo_out[7]), 32'h1);
    for (int i = 0; i < lvl; i++) begin
      pat = bus.uo_out[3:0];
      cnt = 0;
      while (bus.uo_out[3:0] === pat && pat !== 4'h0 && bus.uo_out[7] === 1'b1 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      chk("led_on_cycles", 32'(cnt), 32'd16);
      chk("led_onehot", 32'($countones(pat)), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("step_replay", 32'(pat), 32'(e));
      end else begin
        seq_obs[i] = idx_of(pat);
      end
      cnt = 0;
      while (bus.uo_out[3:0] === 4'h0 && bus.uo_out[7] === 1'b1 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      chk("led_gap_cycles", 32'(cnt), 32'd16);
    end
    chk("input_mode", 32'(bus.uo_out[7:6]), 32'h1);
  endtask

  task automatic press(input logic [1:0] b, input bit mirror);
    bus.ui_in = 8'h80 | (8'h01 << b);
    wait_cycles(4);
    if (mirror) chk("led_mirror", 32'(bus.uo_out[3:0]), 32'(4'b0001 << b));
    bus.ui_in = 8'h80;
    wait_cycles(4);
  endtask

  task automatic fail_press(input logic [7:0] v);
    int cnt;
    bus.ui_in = v;
    cnt = 0;
    while (bus.uo_out[4] !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("fail_latency", 32'(cnt <= 4), 32'h1);
    chk("fail_flags", 32'(bus.uo_out[6:4]), 32'h1);
  endtask

  task automatic check_blink();
    bit saw_on, saw_off, bad;
    saw_on  = 1'b0;
    saw_off = 1'b0;
    bad     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.uo_out[3:0] === 4'hF) saw_on = 1'b1;
      else if (bus.uo_out[3:0] === 4'h0) saw_off = 1'b1;
      else bad = 1'b1;
    end
    chk("fail_blink", 32'({saw_on, saw_off, bad}), 32'h6);
  endtask

  task automatic start_game();
    bus.ui_in = 8'h90;
    wait_cycles(3);
    bus.ui_in = 8'h80;
    wait_cycles(2);
    chk("start_clears", 32'({bus.uo_out[5:4], bus.uio_out}), 32'h0);
  endtask

  initial begin
    bit         quiet_bad;
    logic [1:0] wrong;
    logic [15:0] l;
    logic [1:0] hist [$];
    bit         found, ok;

    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    wait_cycles(5);
    chk("reset_uo_out", 32'(bus.uo_out), 32'h00);
    chk("reset_uio_out", 32'(bus.uio_out), 32'h00);
    chk("reset_uio_oe", 32'(bus.uio_oe), 32'hFF);
    rst_n     = 1'b1;
    bus.ui_in = 8'h80;
    quiet_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.uo_out !== 8'h00) quiet_bad = 1'b1;
    end
    chk("idle_quiet", 32'(quiet_bad), 32'h0);

    // Game 1: one correct round, then a wrong press in round 2
    start_game();
    exp_q.delete();
    observe_show(1);
    press(seq_obs[0], 1'b0);
    wait_cycles(4);
    chk("score_round1", 32'(bus.uio_out), 32'd1);
    exp_q.delete();
    exp_q.push_back(4'b0001 << seq_obs[0]);
    observe_show(2);
    wrong = seq_obs[0] + 2'd1;
    fail_press(8'h80 | (8'h01 << wrong));
    chk("fail_score_held", 32'(bus.uio_out), 32'd1);
    bus.ui_in = 8'h80;
    check_blink();

    // Game 2: chord of buttons 0 and 1 must fail
    start_game();
    exp_q.delete();
    observe_show(1);
    fail_press(8'h83);
    chk("chord_score", 32'(bus.uio_out), 32'd0);
    bus.ui_in = 8'h80;
    wait_cycles(8);

    // Game 3: full game to a win
    start_game();
    for (int r = 1; r <= 16; r++) begin
      exp_q.delete();
      for (int k = 0; k < r - 1; k++) exp_q.push_back(4'b0001 << seq_obs[k]);
      observe_show(r);
      for (int k = 0; k < r; k++) press(seq_obs[k], k < r - 1);
      wait_cycles(4);
      chk("score_round", 32'(bus.uio_out), 32'(r));
    end
    chk("win_outputs", 32'(bus.uo_out[5:0]), 32'h2F);
    chk("win_score", 32'(bus.uio_out), 32'h10);
    chk("win_oe", 32'(bus.uio_oe), 32'hFF);

    // The learnt sequence must be 16 consecutive LFSR samples from the reset seed
    l     = 16'hACE1;
    found = 1'b0;
    for (int n = 0; n < 40000 && !found; n++) begin
      hist.push_back(l[1:0]);
      if (hist.size() > 16) void'(hist.pop_front());
      if (hist.size() == 16) begin
        ok = 1'b1;
        for (int k = 0; k < 16; k++) if (hist[k] !== seq_obs[k]) ok = 1'b0;
        if (ok) found = 1'b1;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    chk("seq_is_lfsr_window", 32'(found), 32'h1);

    start_game();
    exp_q.delete();
    observe_show(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion (%0d vectors, %0d miscompares)",
             n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
